// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: shares one single-port memory between the LCD line
// prefetch reader and the image-processing writer using fixed-length bursts.
module fb_port_arbiter #(
    parameter int AW        = 17,
    parameter int DW        = 24,
    parameter int BURST_LEN = 16,
    parameter int RD_LAT    = 2
) (
    input  logic          lcd_pclk,
    input  logic          rst_n,
    input  logic          rd_req,
    input  logic          rd_urgent,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_grant,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_grant,
    output logic          wr_beat,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int BW = $clog2(BURST_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     start_q, start_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              last_wr_q, last_wr_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DW-1:0]     rd_data_q, rd_data_d;
    logic              rd_accept;

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        beat_d    = beat_q;
        last_wr_d = last_wr_q;
        rd_grant  = 1'b0;
        wr_grant  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                // Urgent reads win outright; otherwise a tie goes to whoever did not own last.
                if (rd_req && (rd_urgent || !wr_req || last_wr_q)) begin
                    rd_grant  = 1'b1;
                    start_d   = rd_addr;
                    beat_d    = '0;
                    last_wr_d = 1'b0;
                    state_d   = RD_BURST;
                end else if (wr_req) begin
                    wr_grant  = 1'b1;
                    start_d   = wr_addr;
                    beat_d    = '0;
                    last_wr_d = 1'b1;
                    state_d   = WR_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                mem_en = 1'b1;
                mem_we = (state_q == WR_BURST);
                if (mem_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr  = mem_en ? (start_q + AW'(beat_q)) : '0;
    assign mem_wdata = wr_data;
    assign wr_beat   = (state_q == WR_BURST) && mem_ready;
    assign busy      = (state_q != IDLE);
    assign rd_accept = (state_q == RD_BURST) && mem_ready;

    // Read return pipe runs independently of the FSM so in-flight beats always land.
    always_comb begin
        vld_d[0] = rd_accept;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        rd_valid_d = vld_q[RD_LAT-1];
        rd_data_d  = vld_q[RD_LAT-1] ? mem_rdata : rd_data_q;
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            start_q    <= '0;
            beat_q     <= '0;
            last_wr_q  <= 1'b1;
            vld_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            beat_q     <= beat_d;
            last_wr_q  <= last_wr_d;
            vld_q      <= vld_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: burst-level reference model, behavioural memory,
// expected-queue scoreboard for read returns, directed plus random traffic.
module tb_fb_port_arbiter;

    localparam int AW = 17;
    localparam int DW = 24;
    localparam int BL = 16;
    localparam int RL = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          rd_req, rd_urgent, rd_grant, rd_valid;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_req, wr_grant, wr_beat;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          mem_en, mem_we, mem_ready, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    fb_port_arbiter #(.AW(AW), .DW(DW), .BURST_LEN(BL), .RD_LAT(RL)) dut (
        .lcd_pclk (clk),
        .rst_n    (rst_n),
        .rd_req   (rd_req),
        .rd_urgent(rd_urgent),
        .rd_addr  (rd_addr),
        .rd_grant (rd_grant),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_grant (wr_grant),
        .wr_beat  (wr_beat),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[7:0] ^ 8'hA5, a[15:0]};
    endfunction

    // ---------------- behavioural memory ----------------
    logic [AW-1:0] acc_a;
    logic [AW-1:0] pipe_a[RL];
    always @(posedge clk) begin
        for (int i = RL - 1; i > 0; i--) pipe_a[i] <= pipe_a[i-1];
        pipe_a[0] <= acc_a;
    end
    assign mem_rdata = mem_word(pipe_a[RL-1]);

    // ---------------- reference model + scoreboard ----------------
    bit            m_busy, m_wr, m_last_wr;
    int            m_beat;
    logic [AW-1:0] m_start, m_exp_addr;
    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    bit            rd_gnt_seen, wr_gnt_seen, wr_beat_seen;

    always @(negedge clk) begin
        int  winner;   // 0 none, 1 read, 2 write
        bit  exp_v;
        if (!rst_n) begin
            chk("rst_ctrl", 32'({rd_grant, wr_grant, rd_valid, wr_beat, mem_en, mem_we, busy}), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_rd_data", 32'(rd_data), 32'd0);
            m_busy    = 1'b0;
            m_last_wr = 1'b1;
            exp_q.delete();
            exp_cyc_q.delete();
        end else begin
            cyc++;
            exp_v = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
            chk("rd_valid", 32'(rd_valid), 32'(exp_v));
            if (exp_v) begin
                chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            if (!m_busy) begin
                winner = 0;
                if (rd_req && rd_urgent)    winner = 1;
                else if (rd_req && wr_req)  winner = m_last_wr ? 1 : 2;
                else if (rd_req)            winner = 1;
                else if (wr_req)            winner = 2;
                chk("rd_grant", 32'(rd_grant), 32'(winner == 1));
                chk("wr_grant", 32'(wr_grant), 32'(winner == 2));
                chk("idle_mem_en", 32'(mem_en), 32'd0);
                chk("idle_busy", 32'(busy), 32'd0);
                if (winner != 0) begin
                    m_busy    = 1'b1;
                    m_wr      = (winner == 2);
                    m_beat    = 0;
                    m_start   = m_wr ? wr_addr : rd_addr;
                    m_last_wr = m_wr;
                end
            end else begin
                m_exp_addr = AW'(m_start + AW'(m_beat));
                chk("burst_grants", 32'({rd_grant, wr_grant}), 32'd0);
                chk("burst_mem_en", 32'(mem_en), 32'd1);
                chk("burst_busy", 32'(busy), 32'd1);
                chk("mem_we", 32'(mem_we), 32'(m_wr));
                chk("mem_addr", 32'(mem_addr), 32'(m_exp_addr));
                chk("wr_beat", 32'(wr_beat), 32'(m_wr && mem_ready));
                if (m_wr) chk("mem_wdata", 32'(mem_wdata), 32'(wr_data));
                if (mem_ready) begin
                    if (!m_wr) begin
                        acc_a = m_exp_addr;
                        exp_q.push_back(mem_word(m_exp_addr));
                        exp_cyc_q.push_back(cyc + RL + 1);
                    end
                    m_beat++;
                    if (m_beat == BL) m_busy = 1'b0;
                end
            end
            if (rd_grant) rd_gnt_seen = 1'b1;
            if (wr_grant) wr_gnt_seen = 1'b1;
            if (wr_beat)  wr_beat_seen = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (rd_gnt_seen) begin rd_req = 1'b0; rd_urgent = 1'b0; rd_gnt_seen = 1'b0; end
        if (wr_gnt_seen) begin wr_req = 1'b0; wr_gnt_seen = 1'b0; end
        if (wr_beat_seen) begin wr_data = DW'($urandom); wr_beat_seen = 1'b0; end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((m_busy || rd_req || wr_req || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_err++;
            $display("FAIL %s: still active after %0d cycles, required idle", name, budget);
        end
        step();
    endtask

    task automatic wait_beat(input string name, input bit want_wr, input int beat, input int budget);
        int n;
        n = 0;
        while (!(m_busy && m_wr == want_wr && m_beat == beat) && n < budget) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_err++;
            $display("FAIL %s: beat %0d not reached in %0d cycles", name, beat, budget);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; rd_req = 1'b0; rd_urgent = 1'b0; rd_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = DW'($urandom); mem_ready = 1'b1;
        acc_a = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // single read burst at 0x100 with memory always ready
        rd_req = 1'b1; rd_addr = 17'h00100;
        wait_idle("read_0x100", 100);

        // write burst that wraps past the top of the address space
        wr_req = 1'b1; wr_addr = 17'h1FFF8;
        wait_idle("write_wrap", 100);

        // both requesters held continuously: grants must alternate
        for (int i = 0; i < 120; i++) begin
            step();
            if (i < 100) begin
                if (!rd_req) begin rd_req = 1'b1; rd_addr = AW'($urandom); end
                if (!wr_req) begin wr_req = 1'b1; wr_addr = AW'($urandom); end
            end
        end
        wait_idle("alternate", 200);

        // urgent read raised while a write burst is running
        wr_req = 1'b1; wr_addr = 17'h04000;
        wait_beat("urgent_setup", 1'b1, 3, 20);
        rd_req = 1'b1; rd_urgent = 1'b1; rd_addr = 17'h08000;
        step();
        wr_req = 1'b1; wr_addr = 17'h0C000;
        wait_idle("urgent", 200);

        // memory stalls for three cycles in the middle of a write burst
        wr_req = 1'b1; wr_addr = 17'h12340;
        wait_beat("stall_setup", 1'b1, 4, 20);
        mem_ready = 1'b0;
        repeat (3) step();
        mem_ready = 1'b1;
        wait_idle("stall", 100);

        // randomized traffic with random memory back-pressure
        for (int i = 0; i < 800; i++) begin
            step();
            if (!rd_req && $urandom_range(0, 3) == 0) begin rd_req = 1'b1; rd_addr = AW'($urandom); end
            rd_urgent = rd_req && ($urandom_range(0, 3) == 0);
            if (!wr_req && $urandom_range(0, 3) == 0) begin wr_req = 1'b1; wr_addr = AW'($urandom); end
            mem_ready = ($urandom_range(0, 3) != 0);
        end
        mem_ready = 1'b1;
        wait_idle("random", 300);

        // reset in the middle of a read burst drops all in-flight data
        rd_req = 1'b1; rd_addr = 17'h02000;
        wait_beat("reset_setup", 1'b0, 5, 20);
        rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; rd_urgent = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        rd_req = 1'b1; rd_addr = 17'h03000;
        wait_idle("after_reset", 100);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
